// File: rtl/ex_muldiv_seq.sv
// Sequential RV32M mul/div unit for EX: shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies; divides stay iterative.
module ex_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StartE,
    input  logic            KillE,
    input  logic [2:0]      MdOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultMDE
);

    localparam int W2 = 2 * XLEN;
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op;
    logic            na;
    logic            nb;
    logic [XLEN-1:0] bm;
    logic [W2-1:0]   acc;

    logic            in_sa;
    logic            in_sb;
    logic            in_na;
    logic            in_nb;
    logic [XLEN-1:0] am_in;
    logic [XLEN-1:0] bm_in;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] spec_res;

    logic [XLEN:0]   mul_sum;
    logic [W2-1:0]   mul_nxt;
    logic [XLEN:0]   div_sh;
    logic [XLEN:0]   div_df;
    logic [W2-1:0]   div_nxt;
    logic [W2-1:0]   acc_nxt;

    // Signs are stripped up front; the unsigned core result gets re-signed here.
    function automatic logic [XLEN-1:0] fin_res(
        input logic [2:0]    f,
        input logic [W2-1:0] p,
        input logic          sa_n,
        input logic          sb_n
    );
        logic [W2-1:0]   ps;
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        ps = (sa_n ^ sb_n) ? -p : p;
        q  = (sa_n ^ sb_n) ? -p[XLEN-1:0] : p[XLEN-1:0];
        r  = sa_n ? -p[W2-1:XLEN] : p[W2-1:XLEN];
        case (f)
            3'd0:                fin_res = ps[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fin_res = ps[W2-1:XLEN];
            3'd4, 3'd5:          fin_res = q;
            default:             fin_res = r;
        endcase
    endfunction

    always_comb begin
        in_sa = (MdOpE != 3'd3) && (MdOpE != 3'd5) && (MdOpE != 3'd7);
        in_sb = (MdOpE == 3'd0) || (MdOpE == 3'd1)
             || (MdOpE == 3'd4) || (MdOpE == 3'd6);
        in_na = in_sa & SrcAE[XLEN-1];
        in_nb = in_sb & SrcBE[XLEN-1];
        am_in = in_na ? -SrcAE : SrcAE;
        bm_in = in_nb ? -SrcBE : SrcBE;
        div0  = MdOpE[2] && (SrcBE == '0);
        ovf   = MdOpE[2] && !MdOpE[0]
             && (SrcAE == {1'b1, {(XLEN-1){1'b0}}})
             && (SrcBE == '1);
        if (div0)
            spec_res = MdOpE[1] ? SrcAE : '1;
        else
            spec_res = MdOpE[1] ? '0 : SrcAE;
    end

    // acc holds {hi, lo}: mul = {partial sum, multiplier}; div = {rem, quotient}.
    always_comb begin
        mul_sum = {1'b0, acc[W2-1:XLEN]} + (acc[0] ? {1'b0, bm} : '0);
        mul_nxt = {mul_sum, acc[XLEN-1:1]};
        div_sh  = acc[W2-1:XLEN-1];
        div_df  = div_sh - {1'b0, bm};
        if (div_df[XLEN])
            div_nxt = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            div_nxt = {div_df[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        acc_nxt = op[2] ? div_nxt : mul_nxt;
    end

    assign BusyE = ((state == IDLE) && StartE) || (state == CALC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            na        <= 1'b0;
            nb        <= 1'b0;
            bm        <= '0;
            acc       <= '0;
            DoneE     <= 1'b0;
            ResultMDE <= '0;
        end else begin
            DoneE <= 1'b0;
            case (state)
                IDLE: begin
                    if (StartE && !KillE) begin
                        op  <= MdOpE;
                        na  <= in_na;
                        nb  <= in_nb;
                        bm  <= bm_in;
                        acc <= {{XLEN{1'b0}}, am_in};
                        cnt <= '0;
                        if (div0 || ovf) begin
                            ResultMDE <= spec_res;
                            DoneE     <= 1'b1;
                            state     <= DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!MdOpE[2]) begin
                            ResultMDE <= fin_res(MdOpE,
                                {{XLEN{1'b0}}, am_in} * {{XLEN{1'b0}}, bm_in},
                                in_na, in_nb);
                            DoneE     <= 1'b1;
                            state     <= DONE;
                        end
`endif
                        else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (KillE) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(XLEN - 1)) begin
                            ResultMDE <= fin_res(op, acc_nxt, na, nb);
                            DoneE     <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
